// File: rtl/demux32_1to2_fifo.sv
// One-to-two word router: each accepted input word is steered by in_sel into
// one of two independent per-channel FIFOs, each with its own routed-word counter.

module demux32_1to2_fifo_chan #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [31:0]      wr_data,
  input  logic             pop_req,
  output logic [31:0]      out_data,
  output logic             out_valid,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;

  logic [31:0]      mem_q [DEPTH];
  logic [31:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pop_s;

  // Next-state: pointers wrap naturally at DEPTH; pops on an empty FIFO are dropped.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    pop_s    = pop_req & (occ_q != {OCC_W{1'b0}});
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      cnt_d           = cnt_q + CNT_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop_s})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers; storage is cleared too so stale words can never resurface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      occ_q    <= {OCC_W{1'b0}};
      cnt_q    <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = (occ_q != {OCC_W{1'b0}});
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign full      = (occ_q == OCC_W'(DEPTH));
  assign cnt       = cnt_q;

endmodule

module demux32_1to2_fifo #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      outA_data,
  output logic             outA_valid,
  input  logic             outA_ready,
  output logic [31:0]      outB_data,
  output logic             outB_valid,
  input  logic             outB_ready,
  output logic [CNT_W-1:0] cntA,
  output logic [CNT_W-1:0] cntB,
  output logic             fullA,
  output logic             fullB
);

  logic push_a_s;
  logic push_b_s;

  // A full channel refuses input even if it pops this cycle: no pass-through.
  assign in_ready = in_sel ? ~fullB : ~fullA;
  assign push_a_s = in_valid & in_ready & ~in_sel;
  assign push_b_s = in_valid & in_ready &  in_sel;

  demux32_1to2_fifo_chan #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_a_s),
    .wr_data   (in_data),
    .pop_req   (outA_ready),
    .out_data  (outA_data),
    .out_valid (outA_valid),
    .full      (fullA),
    .cnt       (cntA)
  );

  demux32_1to2_fifo_chan #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_chan_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_b_s),
    .wr_data   (in_data),
    .pop_req   (outB_ready),
    .out_data  (outB_data),
    .out_valid (outB_valid),
    .full      (fullB),
    .cnt       (cntB)
  );

endmodule

// File: tb/tb_demux32_1to2_fifo.sv
// Randomized and directed bench for demux32_1to2_fifo against a queue-based
// reference model of the two channels.

module tb_demux32_1to2_fifo;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      outA_data, outB_data;
  logic             outA_valid, outB_valid;
  logic             outA_ready, outB_ready;
  logic [CNT_W-1:0] cntA, cntB;
  logic             fullA, fullB;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          mcnt_a = 0;
  int          mcnt_b = 0;

  always #5 clk = ~clk;

  demux32_1to2_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .outA_data  (outA_data),
    .outA_valid (outA_valid),
    .outA_ready (outA_ready),
    .outB_data  (outB_data),
    .outB_valid (outB_valid),
    .outB_ready (outB_ready),
    .cntA       (cntA),
    .cntB       (cntB),
    .fullA      (fullA),
    .fullB      (fullB)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against what the queues say right now.
  task automatic check_outputs();
    chk("outA_valid", {31'd0, outA_valid}, {31'd0, qa.size() != 0});
    chk("outB_valid", {31'd0, outB_valid}, {31'd0, qb.size() != 0});
    chk("outA_data", outA_data, (qa.size() != 0) ? qa[0] : 32'd0);
    chk("outB_data", outB_data, (qb.size() != 0) ? qb[0] : 32'd0);
    chk("fullA", {31'd0, fullA}, {31'd0, qa.size() == DEPTH});
    chk("fullB", {31'd0, fullB}, {31'd0, qb.size() == DEPTH});
    chk("cntA", {28'd0, cntA}, 32'(mcnt_a % (1 << CNT_W)));
    chk("cntB", {28'd0, cntB}, 32'(mcnt_b % (1 << CNT_W)));
    chk("in_ready", {31'd0, in_ready},
        {31'd0, (in_sel ? qb.size() : qa.size()) < DEPTH});
  endtask

  // One clock: drive at negedge, check, then advance the model at the posedge.
  task automatic step(input logic v, input logic sel, input logic [31:0] d,
                      input logic ra, input logic rb);
    bit acc, pa, pb;
    @(negedge clk);
    in_valid   = v;
    in_sel     = sel;
    in_data    = d;
    outA_ready = ra;
    outB_ready = rb;
    #1;
    check_outputs();
    acc = v && ((sel ? qb.size() : qa.size()) < DEPTH);
    pa  = ra && (qa.size() != 0);
    pb  = rb && (qb.size() != 0);
    @(posedge clk);
    if (pa) void'(qa.pop_front());
    if (pb) void'(qb.pop_front());
    if (acc) begin
      if (sel) begin
        qb.push_back(d);
        mcnt_b++;
      end else begin
        qa.push_back(d);
        mcnt_a++;
      end
    end
  endtask

  // Reset asserted between edges; effects must be visible before any clock edge.
  task automatic mid_reset();
    @(negedge clk);
    in_valid   = 1'b0;
    outA_ready = 1'b0;
    outB_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    qa.delete();
    qb.delete();
    mcnt_a = 0;
    mcnt_b = 0;
    check_outputs();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cb0;
    rst_n      = 1'b0;
    in_data    = 32'd0;
    in_sel     = 1'b0;
    in_valid   = 1'b0;
    outA_ready = 1'b0;
    outB_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // Route
    step(1'b1, 1'b0, 32'h1111_1111, 1'b1, 1'b1);
    #1 chk("route_a", outA_data, 32'h1111_1111);
    step(1'b1, 1'b1, 32'h2222_2222, 1'b1, 1'b1);
    #1 chk("route_b", outB_data, 32'h2222_2222);
    chk("route_cntA", {28'd0, cntA}, 32'd1);
    chk("route_cntB", {28'd0, cntB}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Fill A, hold third word, B accepted meanwhile, then full-with-pop
    step(1'b1, 1'b0, 32'h0000_00A0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_00A1, 1'b0, 1'b0);
    #1 chk("fill_fullA", {31'd0, fullA}, 32'd1);
    step(1'b1, 1'b0, 32'h0000_00A2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h0000_00B0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0000_00A2, 1'b1, 1'b0);
    #1 chk("fullpop_head", outA_data, 32'h0000_00A1);
    step(1'b1, 1'b0, 32'h0000_00A2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);

    // Streaming on B at occupancy 1
    step(1'b1, 1'b1, 32'hB000_0000, 1'b0, 1'b0);
    cb0 = mcnt_b;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b1);
    end
    #1 chk("stream_cntB", {28'd0, cntB}, 32'((cb0 + 8) % 16));
    chk("stream_valid", {31'd0, outB_valid}, 32'd1);
    chk("stream_head", outB_data, 32'hB000_0008);

    // Mid-op reset with both FIFOs holding words, then counter wrap
    step(1'b1, 1'b0, 32'hDEAD_0001, 1'b0, 1'b0);
    mid_reset();
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 32'hC000_0000 + 32'(i), 1'b1, 1'b0);
    end
    #1 chk("wrap_cntA", {28'd0, cntA}, 32'd1);
    chk("wrap_head", outA_data, 32'hC000_0010);
    chk("wrap_b_empty", {31'd0, outB_valid}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom,
           $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 6);
      if (i == 200) mid_reset();
    end
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
